// File: rtl/spi_slave.sv
// SPI mode-0 slave. SCLK/CS_N/MOSI are synchronized into the CLK domain. Received
// MSB-first words go to R_DATA. Transmit words come from a one-entry holding register.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCLK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic                  W_STB,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  W_READY,
    output logic                  R_STB,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  TX_UNDERRUN
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  r_state, w_next_state;
    logic [SYNC_STAGES-1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                    r_sclk_d;
    logic [CW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_rx_shift, r_tx_shift, r_hold, r_rdata;
    logic                    r_hold_valid, r_boundary, r_rstb, r_underrun;

    logic                    w_sclk, w_cs_n, w_mosi, w_sclk_rise, w_sclk_fall;
    logic                    w_rx_shift, w_word_done, w_tx_load, w_tx_shift, w_accept;
    logic [DATA_WIDTH-1:0]   w_rx_next;

    // NOTE: the pins are asynchronous to CLK; nothing below may look at them directly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_N};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    assign w_accept    = W_STB & ~r_hold_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        w_next_state = r_state;
        w_rx_shift   = 1'b0;
        w_word_done  = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cs_n) begin
                    w_next_state = ACTIVE;
                    w_tx_load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_n) begin
                    w_next_state = IDLE;
                end else begin
                    w_rx_shift  = w_sclk_rise;
                    w_word_done = w_sclk_rise && (r_bit_cnt == CW'(DATA_WIDTH-1));
                    w_tx_load   = w_sclk_fall && r_boundary;
                    w_tx_shift  = w_sclk_fall && !r_boundary;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '1;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_boundary   <= 1'b0;
            r_rdata      <= '0;
            r_rstb       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_rstb     <= w_word_done;
            r_underrun <= w_tx_load && !r_hold_valid;

            // An abandoned partial word simply never reaches R_DATA.
            if (r_state == IDLE) begin
                r_bit_cnt  <= '0;
                r_boundary <= 1'b0;
            end else if (w_rx_shift) begin
                r_rx_shift <= w_rx_next;
                if (w_word_done) begin
                    r_rdata    <= w_rx_next;
                    r_bit_cnt  <= '0;
                    r_boundary <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_tx_load) begin
                r_tx_shift   <= r_hold_valid ? r_hold : '1;
                r_hold_valid <= 1'b0;
                r_boundary   <= 1'b0;
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b1};
            end

            // A write accepted during an underrun load refills the now-empty register.
            if (w_accept) begin
                r_hold       <= W_DATA;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign MISO        = r_tx_shift[DATA_WIDTH-1];
    assign MISO_OE     = ~w_cs_n;
    assign W_READY     = ~r_hold_valid;
    assign R_STB       = r_rstb;
    assign R_DATA      = r_rdata;
    assign TX_UNDERRUN = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master task, a transmit-side model,
// table-driven single-word frames, hand-written corner sequences and random frames.
module tb_spi_slave;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SCLK = 1'b0;
    logic          CS_N = 1'b1;
    logic          MOSI = 1'b0;
    logic          MISO, MISO_OE, W_READY, R_STB, TX_UNDERRUN;
    logic          W_STB = 1'b0;
    logic [DW-1:0] W_DATA = '0;
    logic [DW-1:0] R_DATA;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .W_STB(W_STB), .W_DATA(W_DATA),
        .W_READY(W_READY), .R_STB(R_STB), .R_DATA(R_DATA), .TX_UNDERRUN(TX_UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int half_ns  = 63;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: counts pulses and logs each received word.
    int            rstb_total = 0;
    int            urun_total = 0;
    logic [DW-1:0] rdata_log[$];
    int            urun_at_rstb[$];
    always @(negedge CLK) begin
        if (TX_UNDERRUN) urun_total++;
        if (R_STB) begin
            rstb_total++;
            rdata_log.push_back(R_DATA);
            urun_at_rstb.push_back(urun_total);
        end
    end

    // Transmit-side model: a one-entry holding register; each load takes it or yields all ones.
    logic [DW-1:0] m_hold = '0;
    bit            m_full = 1'b0;
    int            m_urun = 0;

    function automatic void m_write(input logic [DW-1:0] d);
        if (!m_full) begin
            m_hold = d;
            m_full = 1'b1;
        end
    endfunction

    function automatic logic [DW-1:0] m_load();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        m_urun++;
        return '1;
    endfunction

    logic [DW-1:0] mo[4];
    logic [DW-1:0] mi[4];

    task automatic write_word(input logic [DW-1:0] d);
        @(negedge CLK);
        W_DATA = d;
        W_STB  = 1'b1;
        @(negedge CLK);
        W_STB  = 1'b0;
    endtask

    task automatic spi_bit(input logic b, output logic rb);
        MOSI = b;
        #(half_ns);
        SCLK = 1'b1;
        rb   = MISO;
        #(half_ns);
        SCLK = 1'b0;
    endtask

    // Full frame of n words from mo[], MISO words captured into mi[].
    task automatic run_frame(input int n);
        logic rb;
        CS_N = 1'b0;
        #(half_ns);
        for (int w = 0; w < n; w++)
            for (int b = DW - 1; b >= 0; b--) begin
                spi_bit(mo[w][b], rb);
                mi[w][b] = rb;
            end
        #(half_ns);
        CS_N = 1'b1;
        #(half_ns * 3);
    endtask

    typedef struct {
        logic [DW-1:0] mosi;
        bit            preload;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic [DW-1:0] exp_miso;
        int            exp_urun;
        int            exp_urun_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int            s_r, s_u, n, t;
        logic          rb;
        logic [DW-1:0] pw;
        logic [DW-1:0] exp_tx[4];

        // Single-word frames; a trailing load after the last bit empties the holding register.
        vecs[0] = '{8'h55, 1'b1, 8'hA5, 8'h55, 8'hA5, 1, 0};
        vecs[1] = '{8'h12, 1'b0, 8'h00, 8'h12, 8'hFF, 2, 1};
        vecs[2] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00, 1, 0};
        vecs[4] = '{8'hC6, 1'b1, 8'h6B, 8'hC6, 8'h6B, 1, 0};

        repeat (3) @(negedge CLK);
        check("reset MISO", MISO, 1'b1);
        check("reset MISO_OE", MISO_OE, 1'b0);
        check("reset W_READY", W_READY, 1'b1);
        check("reset R_STB", R_STB, 1'b0);
        check("reset R_DATA", R_DATA, 8'h00);
        check("reset TX_UNDERRUN", TX_UNDERRUN, 1'b0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].preload) begin
                write_word(vecs[i].wdata);
                @(negedge CLK);
                check("vec W_READY after write", W_READY, 1'b0);
            end
            mo[0] = vecs[i].mosi;
            s_r = rstb_total;
            s_u = urun_total;
            run_frame(1);
            check("vec R_STB count", rstb_total - s_r, 1);
            check("vec R_DATA", R_DATA, vecs[i].exp_rdata);
            check("vec master rx", mi[0], vecs[i].exp_miso);
            check("vec underrun count", urun_total - s_u, vecs[i].exp_urun);
            if (rstb_total > s_r)
                check("vec underrun before R_STB", urun_at_rstb[s_r] - s_u, vecs[i].exp_urun_first);
            check("vec W_READY after frame", W_READY, 1'b1);
        end

        // Two-word frame with the second TX word written once W_READY returns.
        write_word(8'h3C);
        @(negedge CLK);
        check("2w W_READY after write", W_READY, 1'b0);
        mo[0] = 8'h29;
        mo[1] = 8'h63;
        s_r = rstb_total;
        fork
            run_frame(2);
            begin
                t = 0;
                while (W_READY !== 1'b1 && t < 500) begin
                    @(negedge CLK);
                    t++;
                end
                check("2w W_READY timeout", (t < 500), 1'b1);
                write_word(8'hC3);
            end
        join
        check("2w R_STB count", rstb_total - s_r, 2);
        if (rstb_total - s_r >= 2) begin
            check("2w word0", rdata_log[s_r], 8'h29);
            check("2w word1", rdata_log[s_r+1], 8'h63);
        end
        check("2w master rx0", mi[0], 8'h3C);
        check("2w master rx1", mi[1], 8'hC3);

        // Aborted partial word, then a full frame.
        s_r = rstb_total;
        CS_N = 1'b0;
        #(half_ns);
        for (int b = 0; b < 3; b++) spi_bit(1'b0, rb);
        #(half_ns);
        CS_N = 1'b1;
        #(half_ns * 3);
        check("partial no R_STB", rstb_total - s_r, 0);
        check("partial R_DATA kept", R_DATA, 8'h63);
        mo[0] = 8'h81;
        run_frame(1);
        check("after partial R_STB count", rstb_total - s_r, 1);
        check("after partial R_DATA", R_DATA, 8'h81);

        // Second write while the holding register is full is dropped.
        write_word(8'h11);
        write_word(8'h22);
        @(negedge CLK);
        check("full W_READY", W_READY, 1'b0);
        mo[0] = 8'h5A;
        run_frame(1);
        check("dropped write master rx", mi[0], 8'h11);
        check("dropped write W_READY", W_READY, 1'b1);

        // R_STB latency from the CLK edge that first samples the last SCLK rise.
        CS_N = 1'b0;
        #(half_ns);
        for (int b = DW - 1; b > 0; b--) spi_bit(b[0], rb);
        MOSI = 1'b0;
        #(half_ns);
        @(negedge CLK);
        SCLK = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (R_STB !== 1'b1 && n < 20);
        check("R_STB latency", n, SS + 1);
        #(half_ns);
        SCLK = 1'b0;
        #(half_ns);
        CS_N = 1'b1;
        #(half_ns * 3);
        check("latency R_DATA", R_DATA, 8'hAA);

        // Reset mid-frame, then SCLK activity with CS_N high, then a clean frame.
        s_r = rstb_total;
        CS_N = 1'b0;
        #(half_ns);
        for (int b = 0; b < 4; b++) spi_bit(1'b1, rb);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midreset MISO", MISO, 1'b1);
        check("midreset MISO_OE", MISO_OE, 1'b0);
        check("midreset W_READY", W_READY, 1'b1);
        check("midreset R_DATA", R_DATA, 8'h00);
        check("midreset R_STB", R_STB, 1'b0);
        check("midreset TX_UNDERRUN", TX_UNDERRUN, 1'b0);
        CS_N = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        for (int b = 0; b < 4; b++) spi_bit(1'b1, rb);
        #(half_ns * 3);
        check("postreset no R_STB", rstb_total - s_r, 0);
        check("postreset MISO_OE", MISO_OE, 1'b0);
        mo[0] = 8'h3A;
        run_frame(1);
        check("postreset R_STB count", rstb_total - s_r, 1);
        check("postreset R_DATA", R_DATA, 8'h3A);

        // Random frames against the model.
        m_full = 1'b0;
        for (int f = 0; f < 16; f++) begin
            half_ns = $urandom_range(47, 83);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                pw = DW'($urandom);
                write_word(pw);
                m_write(pw);
                if ($urandom_range(0, 1) == 1) begin
                    pw = DW'($urandom);
                    write_word(pw);
                    m_write(pw);
                end
            end
            t = m_urun;
            for (int w = 0; w < n; w++) begin
                mo[w]     = DW'($urandom);
                exp_tx[w] = m_load();
            end
            void'(m_load());
            s_r = rstb_total;
            s_u = urun_total;
            run_frame(n);
            check("rand R_STB count", rstb_total - s_r, n);
            for (int w = 0; w < n; w++) begin
                if (rstb_total - s_r > w) check("rand rx word", rdata_log[s_r+w], mo[w]);
                check("rand master rx", mi[w], exp_tx[w]);
            end
            check("rand underrun count", urun_total - s_u, m_urun - t);
            check("rand W_READY", W_READY, !m_full);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
